// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte link: receiver state encoding,
// idle levels of the SPI pins and the default frame width.
package spi_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

  localparam logic CS_IDLE   = 1'b1;
  localparam logic SCLK_IDLE = 1'b1;
  localparam logic SDI_IDLE  = 1'b1;

  localparam int DEFAULT_DATA_WIDTH = 8;

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for one asynchronous input bit; the whole chain
// resets to RESET_VAL so the pin looks idle coming out of reset.
module sync_bit #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge CLK) begin
    if (RST) begin
      chain <= {STAGES{RESET_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/spi_byte_receiver.sv
// SPI target receiver: oversamples CS/SCLK/SDI, shifts one byte MSB-first per
// frame and presents it on a single-entry valid/ready register.
module spi_byte_receiver
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  SPI_CS,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_SDI,
  output logic [DATA_WIDTH-1:0] RX_DATA,
  output logic                  RX_VALID,
  input  logic                  RX_READY,
  output logic                  RX_OVERRUN,
  output logic                  RX_ABORT,
  output logic                  BUSY
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  logic cs_sync, sclk_sync, sdi_sync;
  logic sclk_prev, cs_q, sdi_q, rise_q;

  rx_state_t             state, state_next;
  logic [CNT_W-1:0]      count, count_next;
  logic [DATA_WIDTH-1:0] shift, shift_next;
  logic                  commit, abort_next;

  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(CS_IDLE))
    u_sync_cs   (.CLK(CLK), .RST(RST), .d(SPI_CS),   .q(cs_sync));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE))
    u_sync_sclk (.CLK(CLK), .RST(RST), .d(SPI_SCLK), .q(sclk_sync));
  sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(SDI_IDLE))
    u_sync_sdi  (.CLK(CLK), .RST(RST), .d(SPI_SDI),  .q(sdi_sync));

  // Rise event and the CS/SDI it belongs to are registered together, giving
  // the FSM one aligned view one cycle after synchronization.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sclk_prev <= SCLK_IDLE;
      cs_q      <= CS_IDLE;
      sdi_q     <= SDI_IDLE;
      rise_q    <= 1'b0;
    end else begin
      sclk_prev <= sclk_sync;
      cs_q      <= cs_sync;
      sdi_q     <= sdi_sync;
      rise_q    <= sclk_sync & ~sclk_prev;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      count    <= '0;
      shift    <= '0;
      RX_ABORT <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      shift    <= shift_next;
      RX_ABORT <= abort_next;
    end
  end

  // CS deassertion takes priority over a coincident SCLK rise.
  always_comb begin
    state_next = state;
    count_next = count;
    shift_next = shift;
    commit     = 1'b0;
    abort_next = 1'b0;
    case (state)
      IDLE: begin
        count_next = '0;
        shift_next = '0;
        if (!cs_q) state_next = RECV;
      end
      RECV: begin
        if (cs_q) begin
          state_next = IDLE;
          abort_next = (count != '0);
          count_next = '0;
          shift_next = '0;
        end else if (rise_q) begin
          shift_next = {shift[DATA_WIDTH-2:0], sdi_q};
          if (count == CNT_W'(DATA_WIDTH - 1)) begin
            count_next = '0;
            commit     = 1'b1;
          end else begin
            count_next = count + CNT_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // A completed byte replaces the held one only if it is leaving this cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      RX_DATA    <= '0;
      RX_VALID   <= 1'b0;
      RX_OVERRUN <= 1'b0;
    end else begin
      RX_OVERRUN <= 1'b0;
      if (commit) begin
        if (!RX_VALID || RX_READY) begin
          RX_DATA  <= shift_next;
          RX_VALID <= 1'b1;
        end else begin
          RX_OVERRUN <= 1'b1;
        end
      end else if (RX_VALID && RX_READY) begin
        RX_VALID <= 1'b0;
      end
    end
  end

  assign BUSY = (state == RECV);

endmodule
